pad_input_filter_ctrl: RTL and testbench

Controller for the Schmitt-buffered pad input path. It takes N_CH asynchronous pad inputs after the Schmitt buffer stage and synchronises each one into the core clock domain. A time-base prescaler shared by all channels sequences a per-channel debounce counter. The block provides filtered levels, edge pulses, a pending-event register and an interrupt, all configured through a small register port from the management core.

---
 rtl/pad_input_filter_ctrl_if.sv | 30 +++
 rtl/pad_input_filter_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_pad_input_filter_ctrl.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pad_input_filter_ctrl_if.sv
// Register-port bundle between the management core and pad_input_filter_ctrl.
//   cfg_we_i    : write strobe, one cycle
//   cfg_re_i    : read strobe, one cycle
//   cfg_addr_i  : register select (0 CTRL, 1 PRESCALE, 2 THRESH, 3 PENDING)
//   cfg_wdata_i : write data
//   cfg_rdata_o : registered read data, returned by the filter controller
// master drives the strobes/address/data; slave is the filter controller.
interface pad_input_filter_ctrl_if;
  logic        cfg_we_i;
  logic        cfg_re_i;
  logic [1:0]  cfg_addr_i;
  logic [31:0] cfg_wdata_i;
  logic [31:0] cfg_rdata_o;

  modport master (
    output cfg_we_i,
    output cfg_re_i,
    output cfg_addr_i,
    output cfg_wdata_i,
    input  cfg_rdata_o
  );

  modport slave (
    input  cfg_we_i,
    input  cfg_re_i,
    input  cfg_addr_i,
    input  cfg_wdata_i,
    output cfg_rdata_o
  );
endinterface

// File: rtl/pad_input_filter_ctrl.sv
// Pad input filter controller.
// Synchronises N_CH asynchronous Schmitt-buffer outputs into the wb_clk_i
// domain, debounces each one with a counter paced by a shared prescaler,
// and reports filtered levels, one-cycle edge pulses, a sticky pending
// register (W1C) and a level interrupt.
//
// Ports:
//   wb_clk_i  : core clock
//   wb_rst_i  : synchronous reset, active-high
//   pad_in_i  : asynchronous pad levels [N_CH]
//   cfg       : register port (pad_input_filter_ctrl_if.slave)
//   filt_o    : debounced levels [N_CH]
//   rise_o    : rising-edge pulses [N_CH], high in the cycle filt_o rises
//   fall_o    : falling-edge pulses [N_CH], high in the cycle filt_o falls
//   irq_o     : registered OR of PENDING
//
// Registers: 0 CTRL (channel enables), 1 PRESCALE, 2 THRESH, 3 PENDING (W1C).
//
// Build option PAD_FILT_EDGE_SEL_EN: adds EDGE_SEL in the upper half of
// register 1 (bits[23:16] rising-enable, bits[31:24] falling-enable, reset
// all ones) which masks which edge types set PENDING. Without it every edge
// sets PENDING and those bits read 0.
module pad_input_filter_ctrl #(
  parameter int unsigned N_CH  = 8,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned PRE_W = 16
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic [N_CH-1:0]         pad_in_i,
  pad_input_filter_ctrl_if.slave  cfg,
  output logic [N_CH-1:0]         filt_o,
  output logic [N_CH-1:0]         rise_o,
  output logic [N_CH-1:0]         fall_o,
  output logic                    irq_o
);

  typedef enum logic [1:0] {
    ADDR_CTRL     = 2'd0,
    ADDR_PRESCALE = 2'd1,
    ADDR_THRESH   = 2'd2,
    ADDR_PENDING  = 2'd3
  } reg_addr_e;

  reg_addr_e addr;
  assign addr = reg_addr_e'(cfg.cfg_addr_i);

  // Configuration and status registers
  logic [N_CH-1:0]  ctrl;
  logic [PRE_W-1:0] prescale;
  logic [CNT_W-1:0] thresh;
  logic [N_CH-1:0]  pend;

  // Datapath state
  logic [N_CH-1:0]  sync1;
  logic [N_CH-1:0]  sync2;
  logic [PRE_W-1:0] pre_cnt;
  logic [CNT_W-1:0] cnt [N_CH];

  logic             tick;
  logic             wr_ctrl;
  logic             wr_pre;
  logic             wr_thresh;
  logic             wr_pend;
  logic [N_CH-1:0]  pend_set;
  logic [N_CH-1:0]  pend_clr;
  logic [31:0]      rd_val;

  // Upper write-data bits that no field maps to.
  logic             unused_wdata;
  assign unused_wdata = ^cfg.cfg_wdata_i;

  assign wr_ctrl   = cfg.cfg_we_i && (addr == ADDR_CTRL);
  assign wr_pre    = cfg.cfg_we_i && (addr == ADDR_PRESCALE);
  assign wr_thresh = cfg.cfg_we_i && (addr == ADDR_THRESH);
  assign wr_pend   = cfg.cfg_we_i && (addr == ADDR_PENDING);

  assign tick     = (pre_cnt == prescale);
  assign pend_clr = wr_pend ? cfg.cfg_wdata_i[N_CH-1:0] : '0;

`ifdef PAD_FILT_EDGE_SEL_EN
  // Only the first eight channels have an EDGE_SEL bit; any further
  // channels always report both edge types.
  localparam int unsigned ES_W = (N_CH > 8) ? 8 : N_CH;

  logic [ES_W-1:0] rise_en;
  logic [ES_W-1:0] fall_en;
  logic [N_CH-1:0] rise_mask;
  logic [N_CH-1:0] fall_mask;

  always_comb begin
    rise_mask           = '1;
    fall_mask           = '1;
    rise_mask[ES_W-1:0] = rise_en;
    fall_mask[ES_W-1:0] = fall_en;
  end

  assign pend_set = (rise_o & rise_mask) | (fall_o & fall_mask);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rise_en <= '1;
      fall_en <= '1;
    end else if (wr_pre) begin
      rise_en <= cfg.cfg_wdata_i[16 +: ES_W];
      fall_en <= cfg.cfg_wdata_i[24 +: ES_W];
    end
  end
`else
  assign pend_set = rise_o | fall_o;
`endif

  // Read mux; unused bits stay zero.
  always_comb begin
    rd_val = '0;
    case (addr)
      ADDR_CTRL: rd_val[N_CH-1:0] = ctrl;
      ADDR_PRESCALE: begin
        rd_val[PRE_W-1:0] = prescale;
`ifdef PAD_FILT_EDGE_SEL_EN
        rd_val[16 +: ES_W] = rise_en;
        rd_val[24 +: ES_W] = fall_en;
`endif
      end
      ADDR_THRESH:  rd_val[CNT_W-1:0] = thresh;
      ADDR_PENDING: rd_val[N_CH-1:0]  = pend;
      default:      rd_val = '0;
    endcase
  end

  // Register file, prescaler, pending, interrupt and read data
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ctrl            <= '0;
      prescale        <= '0;
      thresh          <= CNT_W'(4);
      pend            <= '0;
      pre_cnt         <= '0;
      irq_o           <= 1'b0;
      cfg.cfg_rdata_o <= '0;
    end else begin
      if (wr_ctrl)   ctrl     <= cfg.cfg_wdata_i[N_CH-1:0];
      if (wr_pre)    prescale <= cfg.cfg_wdata_i[PRE_W-1:0];
      if (wr_thresh) thresh   <= cfg.cfg_wdata_i[CNT_W-1:0];

      // A new event in the same cycle as its W1C clear keeps the bit set.
      pend <= (pend & ~pend_clr) | pend_set;

      irq_o <= |pend;

      if (wr_pre || tick) pre_cnt <= '0;
      else                pre_cnt <= pre_cnt + PRE_W'(1);

      if (cfg.cfg_re_i) cfg.cfg_rdata_o <= rd_val;
    end
  end

  // Two-flop synchronisers; they run regardless of channel enable.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pad_in_i;
      sync2 <= sync1;
    end
  end

  // Per-channel debounce. The STABLE/COUNTING state is not stored: it is
  // simply whether sync2 disagrees with the current filtered level.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      filt_o <= '0;
      rise_o <= '0;
      fall_o <= '0;
      for (int unsigned i = 0; i < N_CH; i++) cnt[i] <= '0;
    end else begin
      rise_o <= '0;
      fall_o <= '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (!ctrl[i] || (sync2[i] == filt_o[i])) begin
          cnt[i] <= '0;
        end else if (tick) begin
          // >= so that lowering THRESH below an in-flight count commits
          // on the next tick instead of wrapping around.
          if (cnt[i] >= thresh) begin
            filt_o[i] <= sync2[i];
            rise_o[i] <= sync2[i];
            fall_o[i] <= ~sync2[i];
            cnt[i]    <= '0;
          end else if (cnt[i] != '1) begin
            cnt[i] <= cnt[i] + CNT_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pad_input_filter_ctrl.sv
module tb_pad_input_filter_ctrl;
  localparam int N = 8;

  logic         clk;
  logic         rst;
  logic [N-1:0] pad;
  logic [N-1:0] filt;
  logic [N-1:0] rise;
  logic [N-1:0] fall;
  logic         irq;

  int n_cmp;
  int n_err;

  pad_input_filter_ctrl_if cfg();

  pad_input_filter_ctrl #(.N_CH(N), .CNT_W(8), .PRE_W(16)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .pad_in_i (pad),
    .cfg      (cfg),
    .filt_o   (filt),
    .rise_o   (rise),
    .fall_o   (fall),
    .irq_o    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------
  // Reference model: each channel's filtered level follows the
  // synchronised pad once the disagreement has lasted through more than
  // THRESH prescaler ticks; events feed a sticky pending set.
  // ---------------------------------------------------------------------
  logic [N-1:0] m_sync1, m_sync2, m_filt, m_rise, m_fall, m_pend, m_ctrl;
  logic [N-1:0] m_rise_en, m_fall_en, mt_set, mt_clr;
  logic         m_irq, mt_tick;
  logic [31:0]  m_rdata, mt_rd;
  int           m_prescale, m_thresh, m_pre;
  int           m_ticks [N];

  always @(posedge clk) begin
    if (rst) begin
      m_sync1 = '0; m_sync2 = '0; m_filt = '0; m_rise = '0; m_fall = '0;
      m_pend = '0; m_ctrl = '0; m_irq = 1'b0; m_rdata = '0;
      m_prescale = 0; m_thresh = 4; m_pre = 0;
      m_rise_en = '1; m_fall_en = '1;
      for (int i = 0; i < N; i++) m_ticks[i] = 0;
    end else begin
      mt_tick = (m_pre == m_prescale);
`ifdef PAD_FILT_EDGE_SEL_EN
      mt_set = (m_rise & m_rise_en) | (m_fall & m_fall_en);
`else
      mt_set = m_rise | m_fall;
`endif
      mt_rd = 32'h0;
      case (cfg.cfg_addr_i)
        2'd0: mt_rd = {24'h0, m_ctrl};
        2'd1: begin
          mt_rd = m_prescale;
`ifdef PAD_FILT_EDGE_SEL_EN
          mt_rd = mt_rd | {m_fall_en, m_rise_en, 16'h0};
`endif
        end
        2'd2: mt_rd = m_thresh;
        default: mt_rd = {24'h0, m_pend};
      endcase
      if (cfg.cfg_re_i) m_rdata = mt_rd;
      m_irq = |m_pend;
      m_rise = '0;
      m_fall = '0;
      for (int i = 0; i < N; i++) begin
        if (!m_ctrl[i] || m_sync2[i] == m_filt[i]) m_ticks[i] = 0;
        else if (mt_tick) begin
          if (m_ticks[i] >= m_thresh) begin
            m_filt[i] = m_sync2[i];
            if (m_sync2[i]) m_rise[i] = 1'b1; else m_fall[i] = 1'b1;
            m_ticks[i] = 0;
          end else m_ticks[i] = m_ticks[i] + 1;
        end
      end
      mt_clr = (cfg.cfg_we_i && cfg.cfg_addr_i == 2'd3) ? cfg.cfg_wdata_i[7:0] : 8'h0;
      m_pend = (m_pend & ~mt_clr) | mt_set;
      if ((cfg.cfg_we_i && cfg.cfg_addr_i == 2'd1) || mt_tick) m_pre = 0;
      else m_pre = m_pre + 1;
      if (cfg.cfg_we_i) begin
        case (cfg.cfg_addr_i)
          2'd0: m_ctrl = cfg.cfg_wdata_i[7:0];
          2'd1: begin
            m_prescale = cfg.cfg_wdata_i[15:0];
            m_rise_en  = cfg.cfg_wdata_i[23:16];
            m_fall_en  = cfg.cfg_wdata_i[31:24];
          end
          2'd2: m_thresh = cfg.cfg_wdata_i[7:0];
          default: ;
        endcase
      end
      m_sync2 = m_sync1;
      m_sync1 = pad;
    end
  end

  // ---------------------------------------------------------------------
  // Drive helpers: every task starts and ends just after a falling edge.
  // ---------------------------------------------------------------------
  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    cfg.cfg_we_i = 1'b1; cfg.cfg_addr_i = a; cfg.cfg_wdata_i = d;
    @(negedge clk);
    cfg.cfg_we_i = 1'b0;
  endtask

  task automatic cfg_read(input logic [1:0] a, output logic [31:0] d);
    cfg.cfg_re_i = 1'b1; cfg.cfg_addr_i = a;
    @(negedge clk);
    cfg.cfg_re_i = 1'b0;
    d = cfg.cfg_rdata_o;
  endtask

  // ---------------------------------------------------------------------
  task automatic test_reset();
    logic [31:0] d;
    logic [31:0] exp_rd [4];
    exp_rd[0] = 32'h0;
`ifdef PAD_FILT_EDGE_SEL_EN
    exp_rd[1] = 32'hFFFF_0000;
`else
    exp_rd[1] = 32'h0;
`endif
    exp_rd[2] = 32'h4;
    exp_rd[3] = 32'h0;
    rst = 1'b1;
    wait_cycles(3);
    n_cmp++;
    if ({filt, rise, fall, irq} !== 25'h0) begin
      n_err++; $display("FAIL reset_outputs: got %h expected 0", {filt, rise, fall, irq});
    end
    n_cmp++;
    if (cfg.cfg_rdata_o !== 32'h0) begin
      n_err++; $display("FAIL reset_rdata: got %h expected 0", cfg.cfg_rdata_o);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int a = 0; a < 4; a++) begin
      cfg_read(a[1:0], d);
      n_cmp++;
      if (d !== exp_rd[a]) begin
        n_err++; $display("FAIL reset_reg%0d: got %h expected %h", a, d, exp_rd[a]);
      end
    end
    n_cmp++;
    if (irq !== 1'b0) begin
      n_err++; $display("FAIL reset_irq: got %b expected 0", irq);
    end
  endtask

  // CTRL=1, PRESCALE=0, THRESH=3: filt rises 5 edges after sync1 capture.
  task automatic test_latency();
    logic [31:0] d;
    logic ef, er, ei;
    cfg_write(2'd0, 32'h1);
    cfg_write(2'd1, 32'hFFFF_0000);
    cfg_write(2'd2, 32'h3);
    wait_cycles(3);
    pad[0] = 1'b1;                 // next rising edge is the capture edge k
    for (int j = 0; j <= 8; j++) begin
      @(negedge clk);              // observing state after edge k+j
      ef = (j >= 5); er = (j == 5); ei = (j >= 7);
      n_cmp++;
      if (filt[0] !== ef) begin
        n_err++; $display("FAIL latency_filt j=%0d: got %b expected %b", j, filt[0], ef);
      end
      n_cmp++;
      if (rise[0] !== er) begin
        n_err++; $display("FAIL latency_rise j=%0d: got %b expected %b", j, rise[0], er);
      end
      n_cmp++;
      if (irq !== ei) begin
        n_err++; $display("FAIL latency_irq j=%0d: got %b expected %b", j, irq, ei);
      end
    end
    cfg_read(2'd3, d);
    n_cmp++;
    if (d !== 32'h1) begin
      n_err++; $display("FAIL latency_pending: got %h expected 1", d);
    end
  endtask

  // A 3-cycle pulse is shorter than THRESH+1 ticks and must vanish.
  task automatic test_glitch();
    logic [31:0] d;
    pad[0] = 1'b0;
    wait_cycles(12);
    cfg_write(2'd3, 32'hFF);
    wait_cycles(2);
    cfg_read(2'd3, d);
    n_cmp++;
    if (d !== 32'h0) begin
      n_err++; $display("FAIL glitch_pre_clear: got %h expected 0", d);
    end
    pad[0] = 1'b1;
    wait_cycles(3);
    pad[0] = 1'b0;
    for (int j = 0; j < 15; j++) begin
      @(negedge clk);
      n_cmp++;
      if (filt[0] !== 1'b0 || rise[0] !== 1'b0 || fall[0] !== 1'b0) begin
        n_err++; $display("FAIL glitch_ch0 j=%0d: got filt=%b rise=%b fall=%b expected 0 0 0", j, filt[0], rise[0], fall[0]);
      end
    end
    cfg_read(2'd3, d);
    n_cmp++;
    if (d !== 32'h0) begin
      n_err++; $display("FAIL glitch_pending: got %h expected 0", d);
    end
  endtask

  // PRESCALE=9, THRESH=2: fall needs 3 ticks after sync2, 22..31 edges.
  task automatic test_prescale();
    int n;
    bit seen;
    cfg_write(2'd0, 32'h3);
    cfg_write(2'd2, 32'h2);
    cfg_write(2'd1, 32'hFFFF_0009);
    pad[1] = 1'b1;
    seen = 0;
    for (int j = 0; j < 100 && !seen; j++) begin
      @(negedge clk);
      if (filt[1] === 1'b1) seen = 1;
    end
    n_cmp++;
    if (!seen) begin
      n_err++; $display("FAIL prescale_rise_timeout: got filt1=%b expected 1 within 100 cycles", filt[1]);
    end
    wait_cycles(3);
    pad[1] = 1'b0;
    seen = 0; n = -1;
    for (int j = 0; j < 100 && !seen; j++) begin
      @(negedge clk);
      if (fall[1] === 1'b1) begin seen = 1; n = j; end
    end
    n_cmp++;
    if (!seen || n < 22 || n > 31) begin
      n_err++; $display("FAIL prescale_fall_delay: got %0d expected 22..31", n);
    end
    n_cmp++;
    if (filt[1] !== 1'b0) begin
      n_err++; $display("FAIL prescale_filt: got %b expected 0", filt[1]);
    end
    @(negedge clk);
    n_cmp++;
    if (fall[1] !== 1'b0) begin
      n_err++; $display("FAIL prescale_fall_width: got %b expected 0", fall[1]);
    end
  endtask

  // W1C in the same cycle as a new set keeps the bit; then clear all.
  task automatic test_set_wins();
    logic [31:0] d;
    bit seen;
    cfg_write(2'd1, 32'hFFFF_0000);
    cfg_write(2'd2, 32'h0);
    cfg_write(2'd3, 32'hFF);
    pad[1] = 1'b1; wait_cycles(6);
    pad[0] = 1'b1; wait_cycles(6);
    cfg_read(2'd3, d);
    n_cmp++;
    if (d !== 32'h3) begin
      n_err++; $display("FAIL setwins_pre: got %h expected 3", d);
    end
    pad[0] = 1'b0;
    seen = 0;
    for (int j = 0; j < 10 && !seen; j++) begin
      @(negedge clk);
      if (fall[0] === 1'b1) seen = 1;
    end
    n_cmp++;
    if (!seen) begin
      n_err++; $display("FAIL setwins_fall_timeout: got fall0=%b expected 1 within 10 cycles", fall[0]);
    end
    cfg_write(2'd3, 32'h1);        // lands on the edge where fall0 sets bit 0
    cfg_read(2'd3, d);
    n_cmp++;
    if (d !== 32'h3) begin
      n_err++; $display("FAIL setwins_same_cycle: got %h expected 3", d);
    end
    cfg_write(2'd3, 32'h3);
    n_cmp++;
    if (irq !== 1'b1) begin
      n_err++; $display("FAIL setwins_irq_lag: got %b expected 1", irq);
    end
    @(negedge clk);
    n_cmp++;
    if (irq !== 1'b0) begin
      n_err++; $display("FAIL setwins_irq_clear: got %b expected 0", irq);
    end
    cfg_read(2'd3, d);
    n_cmp++;
    if (d !== 32'h0) begin
      n_err++; $display("FAIL setwins_cleared: got %h expected 0", d);
    end
  endtask

  // Channel 2 disabled: frozen level, no pulses; re-enable resumes.
  task automatic test_disabled();
    logic f;
    bit seen;
    cfg_write(2'd0, 32'h3);
    f = filt[2];
    for (int j = 0; j < 60; j++) begin
      if ($urandom_range(0, 5) == 0) pad[2] = ~pad[2];
      @(negedge clk);
      n_cmp++;
      if (filt[2] !== f || rise[2] !== 1'b0 || fall[2] !== 1'b0) begin
        n_err++; $display("FAIL disabled_ch2 j=%0d: got filt=%b rise=%b fall=%b expected %b 0 0", j, filt[2], rise[2], fall[2], f);
      end
    end
    pad[2] = ~f;
    wait_cycles(3);
    cfg_write(2'd0, 32'h7);
    seen = 0;
    for (int j = 0; j < 10 && !seen; j++) begin
      @(negedge clk);
      if (filt[2] === ~f) seen = 1;
    end
    n_cmp++;
    if (!seen) begin
      n_err++; $display("FAIL reenable_ch2: got filt=%b expected %b within 10 cycles", filt[2], ~f);
    end
  endtask

  // Reset in the middle of a long count clears everything on that edge.
  task automatic test_reset_mid();
    logic [31:0] d;
    cfg_write(2'd1, 32'hFFFF_0009);
    cfg_write(2'd2, 32'h5);
    pad[0] = ~filt[0];
    wait_cycles(15);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({filt, rise, fall, irq} !== 25'h0) begin
      n_err++; $display("FAIL resetmid_outputs: got %h expected 0", {filt, rise, fall, irq});
    end
    n_cmp++;
    if (cfg.cfg_rdata_o !== 32'h0) begin
      n_err++; $display("FAIL resetmid_rdata: got %h expected 0", cfg.cfg_rdata_o);
    end
    rst = 1'b0;
    pad = '0;
    @(negedge clk);
    cfg_read(2'd2, d);
    n_cmp++;
    if (d !== 32'h4) begin
      n_err++; $display("FAIL resetmid_thresh: got %h expected 4", d);
    end
  endtask

  // Random pads, enables, thresholds and register traffic vs the model.
  task automatic test_random();
    int rate;
    rst = 1'b1; pad = '0;
    wait_cycles(2);
    rst = 1'b0;
    @(negedge clk);
    for (int r = 0; r < 3; r++) begin
      cfg_write(2'd0, $urandom_range(0, 255));
      cfg_write(2'd1, {$urandom_range(0, 65535), 16'($urandom_range(0, 3))});
      cfg_write(2'd2, $urandom_range(0, 4));
      rate = (r == 1) ? 30 : 10;
      for (int c = 0; c < 600; c++) begin
        n_cmp++;
        if (filt !== m_filt || rise !== m_rise || fall !== m_fall) begin
          n_err++; $display("FAIL random_levels c=%0d: got f=%h r=%h fl=%h expected f=%h r=%h fl=%h", c, filt, rise, fall, m_filt, m_rise, m_fall);
        end
        n_cmp++;
        if (irq !== m_irq) begin
          n_err++; $display("FAIL random_irq c=%0d: got %b expected %b", c, irq, m_irq);
        end
        n_cmp++;
        if (cfg.cfg_rdata_o !== m_rdata) begin
          n_err++; $display("FAIL random_rdata c=%0d: got %h expected %h", c, cfg.cfg_rdata_o, m_rdata);
        end
        for (int b = 0; b < N; b++)
          if ($urandom_range(0, rate - 1) == 0) pad[b] = ~pad[b];
        cfg.cfg_we_i = 1'b0;
        cfg.cfg_re_i = 1'b0;
        case ($urandom_range(0, 19))
          0: begin cfg.cfg_we_i = 1'b1; cfg.cfg_addr_i = 2'd3; cfg.cfg_wdata_i = $urandom; end
          1: begin cfg.cfg_we_i = 1'b1; cfg.cfg_addr_i = 2'd2; cfg.cfg_wdata_i = $urandom_range(0, 4); end
          2, 3, 4, 5: begin cfg.cfg_re_i = 1'b1; cfg.cfg_addr_i = 2'($urandom_range(0, 3)); end
          default: ;
        endcase
        @(negedge clk);
      end
      cfg.cfg_we_i = 1'b0;
      cfg.cfg_re_i = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1; pad = '0;
    cfg.cfg_we_i = 1'b0; cfg.cfg_re_i = 1'b0;
    cfg.cfg_addr_i = 2'd0; cfg.cfg_wdata_i = 32'h0;
    @(negedge clk);
    test_reset();
    test_latency();
    test_glitch();
    test_prescale();
    test_set_wins();
    test_disabled();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
